tcm_avalon_flash_controller: RTL
================================

Name: tcm_avalon_flash_controller

Overview:
- Avalon-MM slave to tristate-conduit master for an 8-bit asynchronous parallel flash/SRAM.
- Sits on the initiator side of the tristate conduit bridge translator and drives its in_tcm_* conduit.
- Converts single Avalon read and write transfers into chip-select and strobe cycles with programmable setup, wait and hold timing.
- Data is split into out, in and output-enable; the top-level pin wrapper forms the inout.

Parameters:
ADDR_W, 23, flash byte-address width
DATA_W, 8, data width
SETUP_CYC, 2, cycles with address and cs_n valid before the strobe (0 allowed)
READ_WAIT, 8, read_n low cycles (>=1)
WRITE_WAIT, 8, write_n low cycles (>=1)
HOLD_CYC, 2, cycles after the strobe with address, cs_n and write data held (0 allowed)
TURN_CYC, 2, bus turnaround cycles after a read (only with TCM_TURNAROUND_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  byte address
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  DATA_W  write data
avs_readdata  out  DATA_W  read data, valid while waitrequest=0 on a read
avs_waitrequest  out  1  stall; low for exactly one cycle to complete a transfer
tcm_address_out  out  ADDR_W  conduit address
tcm_read_n_out  out  1  output enable / read strobe, active low
tcm_write_n_out  out  1  write strobe, active low
tcm_chipselect_n_out  out  1  chip select, active low
tcm_data_out  out  DATA_W  data driven to the pins
tcm_data_outen  out  1  1 = pins driven by the controller
tcm_data_in  in  DATA_W  data sampled from the pins

Behaviour:
- Reset state (asynchronous, takes effect immediately, including mid-transfer): state=IDLE.
  - avs_waitrequest=1, avs_readdata=0.
  - tcm_address_out=0, tcm_data_out=0, tcm_data_outen=0.
  - read_n, write_n and cs_n all =1.
- All outputs are registered. Counters are $clog2(max(param)+1) bits and reload on each state entry.
- IDLE: cs_n, read_n and write_n =1; outen=0; waitrequest=1; address and data hold their last values.
  - If avs_read or avs_write is high, latch address, writedata and direction, then go to SETUP (or WAIT if SETUP_CYC=0).
  - If both are high, the write wins.
- SETUP (SETUP_CYC cycles): cs_n=0, address valid, both strobes =1; outen=1 for writes.
- WAIT (READ_WAIT or WRITE_WAIT cycles): cs_n=0; read_n=0 for a read, write_n=0 for a write.
  - On the clock edge ending the last read WAIT cycle, tcm_data_in is registered into avs_readdata.
- HOLD (HOLD_CYC cycles): strobes =1; cs_n=0; address, data and outen unchanged. If HOLD_CYC=0, go directly to DONE.
- DONE (1 cycle): avs_waitrequest=0, cs_n=1, outen=0; readdata is valid for a read. Next state is IDLE, or TURN after a read when the macro is enabled.
- Latency: from the first cycle IDLE sees the request, waitrequest goes low in cycle SETUP_CYC+WAIT+HOLD_CYC+1 (defaults: 13).
- Back-to-back transfers: at least one IDLE cycle between a DONE and the next SETUP; cs_n is high during it.
- avs_readdata holds its value until the next read completes. Writes do not change it.
- Master handshake: the request and its inputs stay stable while waitrequest=1. Input changes after the latch are ignored.
- Address wrap: no arithmetic is applied; an all-ones address is passed through unchanged.

Optional Feature:
Macro TCM_TURNAROUND_EN.
- Defined: after DONE of a read, enter TURN for TURN_CYC cycles (cs_n=1, outen=0, waitrequest=1, requests ignored), then go to IDLE.
  - This guarantees the device releases the bus before the controller drives it again.
- Undefined: the TURN state and TURN_CYC logic are absent; DONE always goes to IDLE.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release -> all strobes =1, outen=0, waitrequest=1, address=0. Assert reset_n=0 during WAIT of a write -> write_n=1 and outen=0 with no clock edge needed.
- Single read, defaults, addr=0x1A2B3C, tcm_data_in=0x5A -> cs_n low for 12 cycles and read_n low for exactly 8; waitrequest low in cycle 13 with readdata=0x5A.
- Single write, addr=0x7FFFFF, data=0xC3 -> outen=1 from SETUP through HOLD, write_n low 8 cycles, data_out=0xC3 stable; waitrequest low one cycle; readdata unchanged.
- SETUP_CYC=0, HOLD_CYC=0, READ_WAIT=1 -> read completes with waitrequest low in cycle 2; read_n low 1 cycle.
- Simultaneous avs_read=avs_write=1 -> write strobe issued, no read strobe. Back-to-back write then read -> at least 1 IDLE cycle with cs_n=1 between them.
- With TCM_TURNAROUND_EN and TURN_CYC=2: read followed by a write held pending -> 2 TURN cycles plus 1 IDLE cycle with outen=0 before write SETUP. Without the macro -> only 1 IDLE cycle.

Source files
------------

// File: rtl/tcm_avalon_flash_controller.sv
// Avalon-MM slave to tristate-conduit master for an 8-bit asynchronous flash/SRAM.
// Optional bus turnaround after reads is enabled by defining TCM_TURNAROUND_EN.
module tcm_avalon_flash_controller #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 2,
    parameter int READ_WAIT  = 8,
    parameter int WRITE_WAIT = 8,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] tcm_address_out,
    output logic              tcm_read_n_out,
    output logic              tcm_write_n_out,
    output logic              tcm_chipselect_n_out,
    output logic [DATA_W-1:0] tcm_data_out,
    output logic              tcm_data_outen,
    input  logic [DATA_W-1:0] tcm_data_in
);

    localparam int MAX_A = (SETUP_CYC > READ_WAIT) ? SETUP_CYC : READ_WAIT;
    localparam int MAX_B = (WRITE_WAIT > HOLD_CYC) ? WRITE_WAIT : HOLD_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL = (MAX_C > TURN_CYC) ? MAX_C : TURN_CYC;
    localparam int CNT_W = $clog2(MAX_ALL + 1);

    // Counters hold "cycles remaining minus one", so zero means last cycle of the state.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] RW_LD    = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WW_LD    = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
`ifdef TCM_TURNAROUND_EN
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_HOLD, S_DONE, S_TURN
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_write;
    logic [DATA_W-1:0] r_readdata;
    logic              r_waitreq;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read_n;
    logic              r_write_n;
    logic              r_cs_n;
    logic [DATA_W-1:0] r_dout;
    logic              r_outen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_readdata <= '0;
            r_waitreq  <= 1'b1;
            r_addr     <= '0;
            r_read_n   <= 1'b1;
            r_write_n  <= 1'b1;
            r_cs_n     <= 1'b1;
            r_dout     <= '0;
            r_outen    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (avs_read || avs_write) begin
                        // Write wins when both requests are asserted.
                        r_is_write <= avs_write;
                        r_addr     <= avs_address;
                        r_dout     <= avs_writedata;
                        r_cs_n     <= 1'b0;
                        r_outen    <= avs_write;
                        if (SETUP_CYC > 0) begin
                            r_state <= S_SETUP;
                            r_cnt   <= SETUP_LD;
                        end else begin
                            r_state   <= S_WAIT;
                            r_cnt     <= avs_write ? WW_LD : RW_LD;
                            r_read_n  <= avs_write;
                            r_write_n <= ~avs_write;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= r_is_write ? WW_LD : RW_LD;
                        r_read_n  <= r_is_write;
                        r_write_n <= ~r_is_write;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_is_write) r_readdata <= tcm_data_in;
                        r_read_n  <= 1'b1;
                        r_write_n <= 1'b1;
                        if (HOLD_CYC > 0) begin
                            r_state <= S_HOLD;
                            r_cnt   <= HOLD_LD;
                        end else begin
                            r_state   <= S_DONE;
                            r_cs_n    <= 1'b1;
                            r_outen   <= 1'b0;
                            r_waitreq <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        r_cs_n    <= 1'b1;
                        r_outen   <= 1'b0;
                        r_waitreq <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_waitreq <= 1'b1;
`ifdef TCM_TURNAROUND_EN
                    if (!r_is_write && TURN_CYC > 0) begin
                        r_state <= S_TURN;
                        r_cnt   <= TURN_LD;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
`ifdef TCM_TURNAROUND_EN
                S_TURN: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avs_readdata         = r_readdata;
    assign avs_waitrequest      = r_waitreq;
    assign tcm_address_out      = r_addr;
    assign tcm_read_n_out       = r_read_n;
    assign tcm_write_n_out      = r_write_n;
    assign tcm_chipselect_n_out = r_cs_n;
    assign tcm_data_out         = r_dout;
    assign tcm_data_outen       = r_outen;

endmodule
